// File: rtl/box_motion_ctrl.sv
// Position/colour source for the box draw/erase engine: moves the box per key on each update pulse.
// Optional `define BOUNCE_EN adds per-axis direction registers so the box keeps moving and bounces off frame edges.
module box_motion_ctrl #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BOX_SIZE = 4,
  parameter int STEP     = 1,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       update,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       pause,
  input  logic [2:0] iColour,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       go,
  output logic       moved
);

  localparam logic signed [8:0] XMAX   = 9'(SCREEN_W - BOX_SIZE);
  localparam logic signed [7:0] YMAX   = 8'(SCREEN_H - BOX_SIZE);
  localparam logic signed [8:0] STEP_X = 9'(STEP);
  localparam logic signed [7:0] STEP_Y = 8'(STEP);

  typedef enum logic [1:0] {IDLE, SAMPLE, CALC, COMMIT} state_t;

  state_t      state;
  logic        k_left, k_right, k_up, k_down;
  logic [2:0]  col_lat;
  logic [7:0]  cand_x;
  logic [6:0]  cand_y;

  logic signed [8:0] dx, cx;
  logic signed [7:0] dy, cy;

`ifdef BOUNCE_EN
  logic signed [8:0] dir_x, dir_x_nxt;
  logic signed [7:0] dir_y, dir_y_nxt;
`endif

  function automatic logic [7:0] clamp_x(input logic signed [8:0] v);
    if (v < 9'sd0)
      return 8'd0;
    else if (v > XMAX)
      return XMAX[7:0];
    else
      return v[7:0];
  endfunction

  function automatic logic [6:0] clamp_y(input logic signed [7:0] v);
    if (v < 8'sd0)
      return 7'd0;
    else if (v > YMAX)
      return YMAX[6:0];
    else
      return v[6:0];
  endfunction

  // Candidate is formed one bit wider than the coordinate so underflow shows up as negative.
  always_comb begin
    dx = '0;
    dy = '0;
    if (k_right && !k_left)
      dx = STEP_X;
    else if (k_left && !k_right)
      dx = -STEP_X;
`ifdef BOUNCE_EN
    else if (!k_left && !k_right)
      dx = dir_x;
`endif
    if (k_down && !k_up)
      dy = STEP_Y;
    else if (k_up && !k_down)
      dy = -STEP_Y;
`ifdef BOUNCE_EN
    else if (!k_up && !k_down)
      dy = dir_y;
`endif
    cx = $signed({1'b0, oX}) + dx;
    cy = $signed({1'b0, oY}) + dy;
`ifdef BOUNCE_EN
    dir_x_nxt = dir_x;
    if (k_right != k_left)
      dir_x_nxt = dx;
    if (cx <= 9'sd0 || cx >= XMAX)
      dir_x_nxt = -dir_x_nxt;
    dir_y_nxt = dir_y;
    if (k_down != k_up)
      dir_y_nxt = dy;
    if (cy <= 8'sd0 || cy >= YMAX)
      dir_y_nxt = -dir_y_nxt;
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= IDLE;
      go      <= 1'b1;
      moved   <= 1'b0;
      oX      <= 8'(X_INIT);
      oY      <= 7'(Y_INIT);
      oColour <= 3'b000;
      k_left  <= 1'b0;
      k_right <= 1'b0;
      k_up    <= 1'b0;
      k_down  <= 1'b0;
`ifdef BOUNCE_EN
      dir_x   <= STEP_X;
      dir_y   <= STEP_Y;
`endif
    end else begin
      moved <= 1'b0;
      case (state)
        IDLE: begin
          if (update && !pause) begin
            state <= SAMPLE;
            go    <= 1'b0;
          end
        end
        SAMPLE: begin
          k_left  <= key_left;
          k_right <= key_right;
          k_up    <= key_up;
          k_down  <= key_down;
          col_lat <= iColour;
          state   <= CALC;
        end
        CALC: begin
          cand_x <= clamp_x(cx);
          cand_y <= clamp_y(cy);
          state  <= COMMIT;
        end
        COMMIT: begin
          oX      <= cand_x;
          oY      <= cand_y;
          oColour <= col_lat;
          moved   <= 1'b1;
          go      <= 1'b1;
          state   <= IDLE;
`ifdef BOUNCE_EN
          dir_x   <= dir_x_nxt;
          dir_y   <= dir_y_nxt;
`endif
        end
        default: begin
          state <= IDLE;
          go    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Directed bench for box_motion_ctrl with default parameters (160x120 frame, 4-pixel box, step 1).
module tb_box_motion_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       update;
  logic       key_left, key_right, key_up, key_down;
  logic       pause;
  logic [2:0] iColour;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       go;
  logic       moved;

  int checks = 0;
  int fails  = 0;

  box_motion_ctrl dut (
    .clock    (clock),
    .resetn   (resetn),
    .update   (update),
    .key_left (key_left),
    .key_right(key_right),
    .key_up   (key_up),
    .key_down (key_down),
    .pause    (pause),
    .iColour  (iColour),
    .oX       (oX),
    .oY       (oY),
    .oColour  (oColour),
    .go       (go),
    .moved    (moved)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Update pulse sampled at the next edge, then wait until one idle cycle after commit.
  task automatic move();
    update = 1'b1;
    step(1);
    update = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    resetn = 1'b0; update = 1'b0; pause = 1'b0; iColour = 3'b000;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    step(2);
    checks++; if (oX !== 8'd0)      begin fails++; $display("FAIL reset_x got %0d want 0", oX); end
    checks++; if (oY !== 7'd0)      begin fails++; $display("FAIL reset_y got %0d want 0", oY); end
    checks++; if (oColour !== 3'd0) begin fails++; $display("FAIL reset_colour got %0d want 0", oColour); end
    checks++; if (go !== 1'b1)      begin fails++; $display("FAIL reset_go got %b want 1", go); end
    checks++; if (moved !== 1'b0)   begin fails++; $display("FAIL reset_moved got %b want 0", moved); end
    resetn = 1'b1;
    step(1);
  endtask

  task automatic test_right_moves();
    key_right = 1'b1;
    iColour   = 3'b100;
    for (int i = 1; i <= 3; i++) begin
      update = 1'b1;
      step(1);
      update = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++; if (go !== 1'b0)    begin fails++; $display("FAIL move%0d_go_busy c%0d got %b want 0", i, c, go); end
        checks++; if (moved !== 1'b0) begin fails++; $display("FAIL move%0d_early_moved c%0d got %b want 0", i, c, moved); end
        if (c < 3) step(1);
      end
      step(1);
      checks++; if (moved !== 1'b1)   begin fails++; $display("FAIL move%0d_moved got %b want 1", i, moved); end
      checks++; if (oX !== 8'(i))     begin fails++; $display("FAIL move%0d_x got %0d want %0d", i, oX, i); end
      checks++; if (oY !== 7'd0)      begin fails++; $display("FAIL move%0d_y got %0d want 0", i, oY); end
      checks++; if (oColour !== 3'd4) begin fails++; $display("FAIL move%0d_colour got %0d want 4", i, oColour); end
      checks++; if (go !== 1'b1)      begin fails++; $display("FAIL move%0d_go_idle got %b want 1", i, go); end
      step(4);
      checks++; if (moved !== 1'b0)   begin fails++; $display("FAIL move%0d_moved_len got %b want 0", i, moved); end
    end
    key_right = 1'b0;
  endtask

  task automatic test_drops();
    int pulses;
    key_right = 1'b1;
    update = 1'b1;
    step(1);
    update = 1'b0;
    step(1);
    update = 1'b1;
    step(1);
    update = 1'b0;
    step(1);
    checks++; if (moved !== 1'b1) begin fails++; $display("FAIL drop_first_moved got %b want 1", moved); end
    checks++; if (oX !== 8'd4)    begin fails++; $display("FAIL drop_first_x got %0d want 4", oX); end
    pulses = 0;
    repeat (6) begin step(1); if (moved) pulses++; end
    checks++; if (pulses != 0)    begin fails++; $display("FAIL drop_calc_pulses got %0d want 0", pulses); end
    checks++; if (oX !== 8'd4)    begin fails++; $display("FAIL drop_calc_x got %0d want 4", oX); end
    pause = 1'b1;
    update = 1'b1;
    step(1);
    update = 1'b0;
    pulses = 0;
    repeat (6) begin if (moved) pulses++; step(1); end
    checks++; if (pulses != 0)    begin fails++; $display("FAIL drop_pause_pulses got %0d want 0", pulses); end
    checks++; if (oX !== 8'd4)    begin fails++; $display("FAIL drop_pause_x got %0d want 4", oX); end
    checks++; if (go !== 1'b1)    begin fails++; $display("FAIL drop_pause_go got %b want 1", go); end
    pause = 1'b0;
    key_right = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    int pulses;
    key_right = 1'b1;
    update = 1'b1;
    step(1);
    update = 1'b0;
    step(1);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    checks++; if (go !== 1'b1)    begin fails++; $display("FAIL midreset_go got %b want 1", go); end
    checks++; if (oX !== 8'd0)    begin fails++; $display("FAIL midreset_x got %0d want 0", oX); end
    pulses = 0;
    repeat (5) begin if (moved) pulses++; step(1); end
    checks++; if (pulses != 0)    begin fails++; $display("FAIL midreset_pulses got %0d want 0", pulses); end
    checks++; if (oX !== 8'd0)    begin fails++; $display("FAIL midreset_x_after got %0d want 0", oX); end
    key_right = 1'b0;
  endtask

  task automatic test_clamp();
    key_right = 1'b1;
    repeat (156) move();
    checks++; if (oX !== 8'd156) begin fails++; $display("FAIL clamp_reach_xmax got %0d want 156", oX); end
    move();
    checks++; if (oX !== 8'd156) begin fails++; $display("FAIL clamp_xmax got %0d want 156", oX); end
    checks++; if (oY !== 7'd0)   begin fails++; $display("FAIL clamp_y_still got %0d want 0", oY); end
    key_right = 1'b0;
    key_up = 1'b1;
    move();
    checks++; if (oY !== 7'd0)   begin fails++; $display("FAIL clamp_ymin got %0d want 0", oY); end
    key_up = 1'b0;
    key_left = 1'b1;
    repeat (146) move();
    checks++; if (oX !== 8'd10)  begin fails++; $display("FAIL clamp_left_to_10 got %0d want 10", oX); end
    key_right = 1'b1;
    move();
    checks++; if (oX !== 8'd10)  begin fails++; $display("FAIL both_keys_x got %0d want 10", oX); end
    key_left = 1'b0;
    key_right = 1'b0;
    key_down = 1'b1;
    repeat (120) move();
    checks++; if (oY !== 7'd116) begin fails++; $display("FAIL clamp_ymax got %0d want 116", oY); end
    key_down = 1'b0;
    repeat (8) begin
      key_left = 1'b1;
      move();
    end
    key_left = 1'b0;
    checks++; if (oX !== 8'd2)   begin fails++; $display("FAIL left_to_2 got %0d want 2", oX); end
    key_left = 1'b1;
    repeat (3) move();
    key_left = 1'b0;
    checks++; if (oX !== 8'd0)   begin fails++; $display("FAIL clamp_xmin got %0d want 0", oX); end
  endtask

  task automatic test_no_key();
    iColour = 3'b010;
    update = 1'b1;
    step(1);
    update = 1'b0;
    step(3);
    checks++; if (moved !== 1'b1)   begin fails++; $display("FAIL nokey_moved got %b want 1", moved); end
    checks++; if (oX !== 8'd0)      begin fails++; $display("FAIL nokey_x got %0d want 0", oX); end
    checks++; if (oY !== 7'd116)    begin fails++; $display("FAIL nokey_y got %0d want 116", oY); end
    checks++; if (oColour !== 3'd2) begin fails++; $display("FAIL nokey_colour got %0d want 2", oColour); end
    step(1);
    checks++; if (moved !== 1'b0)   begin fails++; $display("FAIL nokey_moved_len got %b want 0", moved); end
  endtask

  task automatic test_bounce();
    repeat (155) move();
    checks++; if (oX !== 8'd155) begin fails++; $display("FAIL bounce_x155 got %0d want 155", oX); end
    move();
    checks++; if (oX !== 8'd156) begin fails++; $display("FAIL bounce_x156 got %0d want 156", oX); end
    move();
    checks++; if (oX !== 8'd155) begin fails++; $display("FAIL bounce_x_back got %0d want 155", oX); end
    checks++; if (oY !== 7'd75)  begin fails++; $display("FAIL bounce_y75 got %0d want 75", oY); end
    repeat (74) move();
    checks++; if (oY !== 7'd1)   begin fails++; $display("FAIL bounce_y1 got %0d want 1", oY); end
    checks++; if (oX !== 8'd81)  begin fails++; $display("FAIL bounce_x81 got %0d want 81", oX); end
    move();
    checks++; if (oY !== 7'd0)   begin fails++; $display("FAIL bounce_y0 got %0d want 0", oY); end
    move();
    checks++; if (oY !== 7'd1)   begin fails++; $display("FAIL bounce_y_up got %0d want 1", oY); end
    checks++; if (oX !== 8'd79)  begin fails++; $display("FAIL bounce_x79 got %0d want 79", oX); end
  endtask

  initial begin
    test_reset();
`ifdef BOUNCE_EN
    test_bounce();
`else
    test_right_moves();
    test_drops();
    test_reset_mid_move();
    test_clamp();
    test_no_key();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
